// File: rtl/uart_rx_module.sv
// 8N1 UART receiver: synchronises the RX pin, detects the start edge, samples each bit
// at mid-bit and presents the byte with a one-cycle done strobe (or a framing-error strobe).
module uart_rx_module #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600,
    parameter int BPS_CNT  = CLK_FREQ / BAUD
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Rx_En_Sig,
    input  logic       Rx_Pin_In,
    output logic [7:0] Rx_Data,
    output logic       Rx_Done_Sig,
    output logic       Rx_Err_Sig
);

    localparam int HALF = BPS_CNT / 2;
    localparam int CW   = $clog2(BPS_CNT);
    localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BPS_CNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          s1;
    logic          s2;
    logic          s3;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;

    logic          cnt_clr;
    logic          bit_clr;
    logic          shift_en;
    logic          done_set;
    logic          err_set;

    // s3 is the older sample, so s3=1/s2=0 marks a falling edge on the line
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= Rx_Pin_In;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        bit_clr    = 1'b0;
        shift_en   = 1'b0;
        done_set   = 1'b0;
        err_set    = 1'b0;
        if (!Rx_En_Sig) begin
            state_next = IDLE;
            cnt_clr    = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (s3 && !s2) begin
                        state_next = START;
                        cnt_clr    = 1'b1;
                    end
                end
                START: begin
                    if (baud_cnt == CNT_MID) begin
                        cnt_clr = 1'b1;
                        if (!s2) begin
                            state_next = DATA;
                            bit_clr    = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                DATA: begin
                    if (baud_cnt == CNT_LAST) begin
                        cnt_clr  = 1'b1;
                        shift_en = 1'b1;
                        if (bit_idx == 3'd7) begin
                            state_next = STOP;
                        end
                    end
                end
                STOP: begin
                    // Leaving at mid-stop lets an immediately following start bit be caught
                    if (baud_cnt == CNT_LAST) begin
                        cnt_clr    = 1'b1;
                        state_next = IDLE;
                        if (s2) begin
                            done_set = 1'b1;
                        end else begin
                            err_set = 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_clr    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            baud_cnt <= '0;
        end else if (cnt_clr) begin
            baud_cnt <= '0;
        end else if (state != IDLE) begin
            baud_cnt <= baud_cnt + CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
        end else begin
            if (bit_clr) begin
                bit_idx <= 3'd0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (shift_en) begin
                shift_reg[bit_idx] <= s2;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            Rx_Data     <= 8'h00;
            Rx_Done_Sig <= 1'b0;
            Rx_Err_Sig  <= 1'b0;
        end else begin
            Rx_Done_Sig <= done_set;
            Rx_Err_Sig  <= err_set;
            if (done_set) begin
                Rx_Data <= shift_reg;
            end
        end
    end

endmodule
